// File: rtl/ttl_nibble_add_seq.sv
// Sequences a 4*NIBBLES-bit add/subtract through one shared external 4-bit adder, LSB nibble first.
// Start->Done latency NIBBLES+1 clocks; Start is accepted only in IDLE and otherwise ignored.
module ttl_nibble_add_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   Start,
  input  logic                   Sub,
  input  logic                   CarryIn,
  input  logic [4*NIBBLES-1:0]   OpA,
  input  logic [4*NIBBLES-1:0]   OpB,
  output logic [3:0]             AddA,
  output logic [3:0]             AddB,
  output logic                   AddC0,
  input  logic [3:0]             AddS,
  input  logic                   AddC4,
  output logic                   Busy,
  output logic                   Done,
  output logic [4*NIBBLES-1:0]   Result,
  output logic                   CarryOut,
  output logic                   Overflow
);

  localparam int W     = 4 * NIBBLES;
  localparam int CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [W-1:0]       a_sh_q, a_sh_d;
  logic [W-1:0]       b_sh_q, b_sh_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [W-1:0]       result_q, result_d;
  logic               carry_out_q, carry_out_d;
  logic               overflow_q, overflow_d;

  always_comb begin
    state_d     = state_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;
    AddA        = 4'h0;
    AddB        = 4'h0;
    AddC0       = 1'b0;

    case (state_q)
      IDLE: begin
        if (Start) begin
          // Subtraction is A + ~B + ~borrow, so the same adder serves both modes.
          a_sh_d  = OpA;
          b_sh_d  = Sub ? ~OpB : OpB;
          carry_d = Sub ? ~CarryIn : CarryIn;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        AddA  = a_sh_q[3:0];
        AddB  = b_sh_q[3:0];
        AddC0 = carry_q;
        result_d          = result_q >> 4;
        result_d[W-1 -: 4] = AddS;
        a_sh_d  = a_sh_q >> 4;
        b_sh_d  = b_sh_q >> 4;
        carry_d = AddC4;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          // Top nibble: bit 3 of the shifted operands is now the sign bit.
          overflow_d  = (a_sh_q[3] == b_sh_q[3]) && (AddS[3] != a_sh_q[3]);
          carry_out_d = AddC4;
          state_d     = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
    end
  end

  assign Busy     = (state_q == RUN);
  assign Done     = (state_q == DONE);
  assign Result   = result_q;
  assign CarryOut = carry_out_q;
  assign Overflow = overflow_q;

endmodule

// File: tb/tb_ttl_nibble_add_seq.sv
// Bench for ttl_nibble_add_seq: a 16-bit (NIBBLES=4) and a 4-bit (NIBBLES=1) instance share stimulus,
// each with its own 4-bit adder and an arithmetic reference model checked every cycle.
module tb_ttl_nibble_add_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, sub, cin;
  logic [15:0] opa, opb;

  logic [3:0]  a0, b0, s0, a1, b1, s1;
  logic        c0_0, c4_0, busy0, done0, co0, ov0;
  logic        c0_1, c4_1, busy1, done1, co1, ov1;
  logic [15:0] res0;
  logic [3:0]  res1;

  // Shared external ripple adders (ttl_7483 stand-ins).
  assign {c4_0, s0} = 5'(a0) + 5'(b0) + 5'(c0_0);
  assign {c4_1, s1} = 5'(a1) + 5'(b1) + 5'(c0_1);

  ttl_nibble_add_seq #(.NIBBLES(4)) u_dut4 (
    .Clk(clk), .Reset(rst), .Start(start), .Sub(sub), .CarryIn(cin),
    .OpA(opa), .OpB(opb), .AddA(a0), .AddB(b0), .AddC0(c0_0),
    .AddS(s0), .AddC4(c4_0), .Busy(busy0), .Done(done0),
    .Result(res0), .CarryOut(co0), .Overflow(ov0));

  ttl_nibble_add_seq #(.NIBBLES(1)) u_dut1 (
    .Clk(clk), .Reset(rst), .Start(start), .Sub(sub), .CarryIn(cin),
    .OpA(opa[3:0]), .OpB(opb[3:0]), .AddA(a1), .AddB(b1), .AddC0(c0_1),
    .AddS(s1), .AddC4(c4_1), .Busy(busy1), .Done(done1),
    .Result(res1), .CarryOut(co1), .Overflow(ov1));

  logic [3:0]  w_adda [2];
  logic [3:0]  w_addb [2];
  logic        w_addc [2];
  logic        w_busy [2];
  logic        w_done [2];
  logic [15:0] w_res  [2];
  logic        w_co   [2];
  logic        w_ov   [2];
  assign w_adda[0] = a0;    assign w_adda[1] = a1;
  assign w_addb[0] = b0;    assign w_addb[1] = b1;
  assign w_addc[0] = c0_0;  assign w_addc[1] = c0_1;
  assign w_busy[0] = busy0; assign w_busy[1] = busy1;
  assign w_done[0] = done0; assign w_done[1] = done1;
  assign w_res[0]  = res0;  assign w_res[1]  = {12'h000, res1};
  assign w_co[0]   = co0;   assign w_co[1]   = co1;
  assign w_ov[0]   = ov0;   assign w_ov[1]   = ov1;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[u%0d] at %0t: got 0x%0h expected 0x%0h", nm, inst, $time, act, exp);
    end
  endtask

  function automatic int nib(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  function automatic logic [15:0] mask(input int n);
    return (n == 4) ? 16'hFFFF : 16'h000F;
  endfunction

  // Reference arithmetic on whole operands: unsigned result/carry, signed overflow.
  function automatic void calc(input int n, input logic [15:0] a, input logic [15:0] b,
                               input logic s, input logic c,
                               output logic [15:0] r, output logic co, output logic ov);
    longint w, m, half, ua, ub, sa, sb, sr, cc;
    w    = 4 * n;
    m    = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    ua   = longint'(a) & m;
    ub   = longint'(b) & m;
    cc   = c ? 1 : 0;
    sa   = (ua >= half) ? ua - 2 * half : ua;
    sb   = (ub >= half) ? ub - 2 * half : ub;
    if (!s) begin
      r  = 16'((ua + ub + cc) & m);
      co = (ua + ub + cc) > m;
      sr = sa + sb + cc;
    end else begin
      r  = 16'((ua - ub - cc) & m);
      co = ua >= (ub + cc);
      sr = sa - sb - cc;
    end
    ov = (sr < -half) || (sr >= half);
  endfunction

  // Model state: k = clocks since the accepting edge (0 = idle, 1..n = nibble k-1, n+1 = done).
  int          k   [2] = '{0, 0};
  logic [15:0] ma  [2];
  logic [15:0] mb  [2];
  logic        ms  [2];
  logic        mc  [2];
  logic [15:0] er  [2] = '{16'h0, 16'h0};
  logic        eco [2] = '{1'b0, 1'b0};
  logic        eov [2] = '{1'b0, 1'b0};

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int n, nk;
      logic [15:0] r;
      logic co, ov;
      n  = nib(i);
      nk = k[i];
      if (rst) begin
        nk = 0; er[i] <= 16'h0; eco[i] <= 1'b0; eov[i] <= 1'b0;
      end else if (k[i] == 0) begin
        if (start) begin
          nk = 1;
          ma[i] <= opa & mask(n); mb[i] <= opb & mask(n);
          ms[i] <= sub;           mc[i] <= cin;
        end
      end else if (k[i] <= n) begin
        nk = k[i] + 1;
        if (nk == n + 1) begin
          calc(n, ma[i], mb[i], ms[i], mc[i], r, co, ov);
          er[i] <= r; eco[i] <= co; eov[i] <= ov;
        end
      end else begin
        nk = 0;
      end
      k[i] <= nk;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        int n, j;
        bit run;
        logic [15:0] bx;
        longint lowm, csum;
        logic [3:0] ea, eb;
        logic ec, c0;
        n   = nib(i);
        run = (k[i] >= 1) && (k[i] <= n);
        ea = 4'h0; eb = 4'h0; ec = 1'b0;
        if (run) begin
          j    = k[i] - 1;
          bx   = ms[i] ? (~mb[i] & mask(n)) : mb[i];
          c0   = ms[i] ? ~mc[i] : mc[i];
          lowm = (longint'(1) << (4 * j)) - 1;
          csum = (longint'(ma[i]) & lowm) + (longint'(bx) & lowm) + (c0 ? 1 : 0);
          ea   = ma[i][4*j +: 4];
          eb   = bx[4*j +: 4];
          ec   = ((csum >> (4 * j)) & 1) != 0;
        end
        chk("busy", i, 32'(w_busy[i]), 32'(run));
        chk("done", i, 32'(w_done[i]), 32'(k[i] == n + 1));
        chk("add_a", i, 32'(w_adda[i]), 32'(ea));
        chk("add_b", i, 32'(w_addb[i]), 32'(eb));
        chk("add_c0", i, 32'(w_addc[i]), 32'(ec));
        if (!run) begin
          chk("result", i, 32'(w_res[i]), 32'(er[i]));
          chk("carry_out", i, 32'(w_co[i]), 32'(eco[i]));
          chk("overflow", i, 32'(w_ov[i]), 32'(eov[i]));
        end
      end
    end
  end

  int          t0, t1;
  logic [15:0] seq;

  // One operation; returns Done arrival (clocks after accept) for both instances and AddA trace of u0.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s, input logic c);
    @(negedge clk);
    opa = a; opb = b; sub = s; cin = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t0 = 0; t1 = 0; seq = 16'h0;
    for (int i = 1; i <= 8; i++) begin
      if (done0 && t0 == 0) t0 = i;
      if (done1 && t1 == 0) t1 = i;
      if (i <= 4) seq = {seq[11:0], a0};
      if (i < 8) @(negedge clk);
    end
    chk("latency_n4", 0, t0, 5);
    chk("latency_n1", 1, t1, 2);
  endtask

  int nd0, nd1;

  initial begin
    rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; opa = 16'h0; opb = 16'h0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_busy", 0, 32'(busy0), 0);
    chk("rst_result", 0, 32'(res0), 0);
    chk("rst_add_a", 0, 32'(a0), 0);
    rst = 1'b0;

    run_op(16'h1234, 16'h0FFF, 1'b0, 1'b0);
    chk("lit_result", 0, 32'(res0), 32'h2233);
    chk("lit_model", 0, 32'(er[0]), 32'h2233);
    chk("lit_co", 0, 32'(co0), 0);
    chk("lit_ov", 0, 32'(ov0), 0);
    chk("lit_adda_seq", 0, 32'(seq), 32'h4321);

    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    chk("wrap_result", 0, 32'(res0), 32'h0000);
    chk("wrap_co", 0, 32'(co0), 1);
    chk("wrap_ov", 0, 32'(ov0), 0);

    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    chk("ovf_result", 0, 32'(res0), 32'h8000);
    chk("ovf_co", 0, 32'(co0), 0);
    chk("ovf_ov", 0, 32'(ov0), 1);

    run_op(16'h0005, 16'h0007, 1'b1, 1'b0);
    chk("sub_result", 0, 32'(res0), 32'hFFFE);
    chk("sub_co", 0, 32'(co0), 0);
    chk("sub_ov", 0, 32'(ov0), 0);

    run_op(16'h8000, 16'h0001, 1'b1, 1'b0);
    chk("subov_result", 0, 32'(res0), 32'h7FFF);
    chk("subov_model", 0, 32'(er[0]), 32'h7FFF);
    chk("subov_co", 0, 32'(co0), 1);
    chk("subov_ov", 0, 32'(ov0), 1);

    run_op(16'h000F, 16'h0001, 1'b0, 1'b1);
    chk("n1_result", 1, 32'(res1), 32'h1);
    chk("n1_co", 1, 32'(co1), 1);
    chk("n1_wide_result", 0, 32'(res0), 32'h0011);

    // Start held high: one accept per NIBBLES+2 clocks, later Starts ignored.
    @(negedge clk);
    start = 1'b1; opa = 16'($urandom); opb = 16'($urandom); sub = 1'b0; cin = 1'b0;
    nd0 = 0; nd1 = 0;
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      if (done0) nd0++;
      if (done1) nd1++;
      opa = 16'($urandom); opb = 16'($urandom);
    end
    start = 1'b0;
    chk("held_done_count", 0, nd0, 4);
    chk("held_done_count", 1, nd1, 8);
    repeat (8) @(negedge clk);

    // Reset during the second RUN cycle aborts the operation.
    opa = 16'hABCD; opb = 16'h1111; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 0, 32'(busy0), 0);
    chk("abort_result", 0, 32'(res0), 0);
    chk("abort_add_a", 0, 32'(a0), 0);
    chk("abort_add_b", 0, 32'(b0), 0);
    chk("abort_add_c0", 0, 32'(c0_0), 0);
    nd0 = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done0) nd0++;
    end
    chk("abort_no_done", 0, nd0, 0);
    run_op(16'h0001, 16'h0001, 1'b0, 1'b0);
    chk("post_abort_result", 0, 32'(res0), 32'h0002);

    for (int n = 0; n < 40; n++) begin
      run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Free-running random Start/Reset traffic, checked cycle by cycle against the model.
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      start = 1'($urandom);
      sub   = 1'($urandom);
      cin   = 1'($urandom);
      opa   = 16'($urandom);
      opb   = 16'($urandom);
      rst   = ($urandom_range(0, 49) == 0);
    end
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    repeat (8) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ttl_nibble_add_seq.md
# ttl_nibble_add_seq

Multi-cycle sequencer that performs a WIDTH-bit add or subtract by time-multiplexing a single external 4-bit ripple adder (ttl_7483, WIDTH=4) one nibble per clock, least-significant nibble first. The block latches operands on a start handshake, drives the adder's A/B/C0 inputs, registers each sum nibble and the ripple carry, and reports result, carry and signed overflow with a one-cycle done pulse. It sits between the cpu5 ALU control path and a shared 4-bit adder instance, replacing a wide adder in the simulation model.

## Interface
- NIBBLES, 4, number of 4-bit slices per operation (≥1); operand width W = 4*NIBBLES
- Clk  input  1  rising-edge clock
- Reset  input  1  synchronous, active-high reset
- Start  input  1  request; accepted only in IDLE
- Sub  input  1  0 = A+B+CarryIn, 1 = A−B−CarryIn (CarryIn acts as borrow-in)
- CarryIn  input  1  carry-in (add) / borrow-in (sub), sampled with Start
- OpA  input  W  operand A, sampled with Start
- OpB  input  W  operand B, sampled with Start
- AddA  output  4  to adder A
- AddB  output  4  to adder B
- AddC0  output  1  to adder C0
- AddS  input  4  from adder S
- AddC4  input  1  from adder C4
- Busy  output  1  high while nibbles are being processed
- Done  output  1  one-cycle pulse when Result/CarryOut/Overflow are valid
- Result  output  W  sum/difference, held until next accepted Start
- CarryOut  output  1  final C4; in Sub mode 1 = no borrow
- Overflow  output  1  two's-complement overflow of the W-bit result

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE; Reset overrides everything, including mid-RUN.
- Reset values: Busy=0, Done=0, Result=0, CarryOut=0, Overflow=0, AddA=0, AddB=0, AddC0=0; nibble counter 0.
- IDLE, Start=1: latch a_sh=OpA, b_sh = Sub ? ~OpB : OpB, carry = Sub ? ~CarryIn : CarryIn; counter=0; → RUN. Start=0: stay.
- RUN (combinational drive): AddA=a_sh[3:0], AddB=b_sh[3:0], AddC0=carry. Outside RUN, AddA/AddB/AddC0 are 0.
- RUN each edge: Result shifts right 4 with AddS entering at [W-1:W-4]; a_sh, b_sh shift right 4; carry←AddC4; counter++. On counter = NIBBLES−1: capture Overflow = (a_sh[3]==b_sh[3]) && (AddS[3]!=a_sh[3]), CarryOut=AddC4; → DONE.
- DONE: Done=1 for exactly this cycle; → IDLE unconditionally. Start in DONE is ignored.
- Start while Busy or in DONE: ignored, no effect on operands or state.
- Result, CarryOut, Overflow are not modified in IDLE; overwritten only by the next operation (Result shifts visibly during RUN).
- Arithmetic is modulo 2^W; b inversion is full W bits; counter width ceil(log2(NIBBLES)) with min 1 bit.

## Timing
- Start sampled at edge 0 → RUN for edges 1..NIBBLES (Busy high during those NIBBLES cycles) → Done high in cycle NIBBLES+1.
- Latency Start→Done = NIBBLES+1 clocks; throughput one operation per NIBBLES+2 clocks (earliest next Start is the IDLE cycle after DONE).
- Adder path is combinational through external ttl_7483; AddS/AddC4 sampled on the same edge AddA/AddB/AddC0 are presented.
- Reset asserted in any cycle: next cycle is IDLE with all outputs at reset values; no Done pulse from the aborted operation.

## Test plan
- NIBBLES=4, add 0x1234+0x0FFF, CarryIn=0 → Done at cycle 5, Result=0x2233, CarryOut=0, Overflow=0; AddA sequence 4,3,2,1.
- Add 0xFFFF+0x0001, CarryIn=0 → Result=0x0000, CarryOut=1, Overflow=0; add 0x7FFF+0x0001 → 0x8000, CarryOut=0, Overflow=1.
- Sub 0x0005−0x0007, CarryIn=0 → Result=0xFFFE, CarryOut=0, Overflow=0; sub 0x8000−0x0001 → 0x7FFF, CarryOut=1, Overflow=1.
- Start held high continuously with changing OpA → only one operation per NIBBLES+2 cycles, operands from the accepting cycle used, Start in RUN/DONE ignored.
- Reset asserted at second RUN cycle → next cycle Busy=0, Result=0, AddA/AddB/AddC0=0, no Done; fresh 0x0001+0x0001 afterwards → 0x0002.
- NIBBLES=1: 0xF+0x1, CarryIn=1 → Done at cycle 2, Result=0x1, CarryOut=1.
